tick_stretcher: RTL and testbench

- Converts single-cycle ticks (e.g. from the team's rising-edge detectors, counter terminal counts) into level pulses of programmable width.
- Enforces a programmable minimum low gap between pulses, so a downstream edge detector sees one distinct rising edge per accepted tick.
- Used to drive LEDs, external strobes and slow-clocked logic from fast tick sources.
- Buffers one tick while a pulse or gap is in progress; reports ticks dropped beyond that buffer.

---
 rtl/tick_stretcher_pkg.sv | 20 ++
 rtl/stretch_counter.sv | 27 ++
 rtl/tick_stretcher.sv | 130 +++++++++++++
 tb/tb_tick_stretcher.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_stretcher_pkg.sv
// Shared definitions for the tick stretcher: state encoding and the
// zero-to-one clamp applied to width/gap operands.
package tick_stretcher_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HIGH = ST_HIGH,
    S_GAP  = ST_GAP
  } state_t;

  // A zero operand would mean a zero-length phase; treat it as one cycle.
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/stretch_counter.sv
// Loadable down-counter shared by the HIGH and GAP phases; saturates at zero.
module stretch_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/tick_stretcher.sv
// Stretches single-cycle ticks into level pulses of programmable width,
// separated by a programmable minimum low gap, with one-deep tick buffering.
import tick_stretcher_pkg::*;

module tick_stretcher #(
  parameter int CNT_W     = 8,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  output logic             level,
  output logic             busy,
  output logic             done,
  output logic             missed
);

  localparam bit RETRIG = (RETRIGGER != 0);

  state_t           state_reg;
  logic             pending_reg;
  logic             level_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             missed_reg;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic [CNT_W-1:0] w_load;
  logic [CNT_W-1:0] g_load;

  // Counter reload values are phase length minus one, sampled from the live inputs.
  assign w_load = CNT_W'(clamp1(32'(width)) - 32'd1);
  assign g_load = CNT_W'(clamp1(32'(gap)) - 32'd1);

  stretch_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = w_load;
    case (state_reg)
      S_IDLE: cnt_load = tick;
      S_HIGH: begin
        if (RETRIG && tick) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = g_load;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_zero) cnt_load = pending_reg | tick;
        else          cnt_dec  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pending_reg <= 1'b0;
      level_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      missed_reg  <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      missed_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (tick) begin
            state_reg <= S_HIGH;
            level_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (!RETRIG && tick) begin
            if (pending_reg) missed_reg  <= 1'b1;
            else             pending_reg <= 1'b1;
          end
          // A retrigger on the last high cycle keeps the pulse alive.
          if (cnt_zero && !(RETRIG && tick)) begin
            state_reg <= S_GAP;
            level_reg <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_zero) begin
            if (pending_reg || tick) begin
              state_reg   <= S_HIGH;
              level_reg   <= 1'b1;
              pending_reg <= 1'b0;
              missed_reg  <= pending_reg & tick;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end else if (tick) begin
            if (pending_reg) missed_reg  <= 1'b1;
            else             pending_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign level  = level_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign missed = missed_reg;

endmodule

// File: tb/tb_tick_stretcher.sv
// Scoreboarded bench: directed scenarios push expected output events, a
// negedge monitor pops and compares; a random run checks tick conservation.
module tb_tick_stretcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] width = 8'd0;
  logic [7:0] gap = 8'd0;
  logic level0, busy0, done0, missed0;
  logic level1, busy1, done1, missed1;

  tick_stretcher #(.CNT_W(8), .RETRIGGER(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .width(width), .gap(gap),
    .level(level0), .busy(busy0), .done(done0), .missed(missed0));

  tick_stretcher #(.CNT_W(8), .RETRIGGER(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .width(width), .gap(gap),
    .level(level1), .busy(busy1), .done(done1), .missed(missed1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int cyc; } ev_t;
  ev_t exp_q[$];

  int  errors = 0;
  int  checks = 0;
  int  sel = 0;
  int  base = 0;
  bit  mon_en = 1'b0;
  logic m_level, m_busy, m_done, m_missed;
  logic prev_level = 1'b0, prev_busy = 1'b0;

  assign m_level  = (sel != 0) ? level1  : level0;
  assign m_busy   = (sel != 0) ? busy1   : busy0;
  assign m_done   = (sel != 0) ? done1   : done0;
  assign m_missed = (sel != 0) ? missed1 : missed0;

  // Event kinds, also the order in which same-cycle events are compared.
  localparam int RISE = 0, FALL = 1, BUP = 2, BDN = 3, DONE = 4, MISS = 5;

  function automatic string kname(input int k);
    case (k)
      RISE: return "rise";
      FALL: return "fall";
      BUP:  return "busy_up";
      BDN:  return "busy_dn";
      DONE: return "done";
      default: return "missed";
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic cmp_ev(input int k, input int r);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d expected none", kname(k), r);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != r) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                 kname(k), r, kname(e.kind), e.cyc);
      end else begin
        $display("event %s at cycle %0d ok", kname(k), r);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_level && !prev_level) cmp_ev(RISE, cyc - base);
      if (!m_level && prev_level) cmp_ev(FALL, cyc - base);
      if (m_busy && !prev_busy)   cmp_ev(BUP, cyc - base);
      if (!m_busy && prev_busy)   cmp_ev(BDN, cyc - base);
      if (m_done)                 cmp_ev(DONE, cyc - base);
      if (m_missed)               cmp_ev(MISS, cyc - base);
    end
    prev_level = m_level;
    prev_busy  = m_busy;
  end

  // Drives tick from a bitmask of relative cycles; optional async reset window.
  task automatic run_scn(input string nm, input int s, input int w, input int g,
                         input logic [31:0] mask, input int len,
                         input int rst_at, input int rst_rel);
    logic [31:0] m;
    m = mask;
    sel = s;
    width = 8'(w);
    gap = 8'(g);
    @(negedge clk);
    base = cyc;
    mon_en = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      if (i == rst_rel) rst = 1'b0;
      tick = (i < 32) ? m[i] : 1'b0;
      if (i + 1 == rst_at) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({nm, "_async_level"}, int'(m_level), 0);
        check({nm, "_async_busy"}, int'(m_busy), 0);
      end
    end
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    check({nm, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
    mon_en = 1'b0;
    $display("scenario %s done", nm);
  endtask

  task automatic run_rand(input int w, input int g, input int n);
    int ticks = 0, rises = 0, misses = 0, low_run = 0, min_low = 1000000;
    bit seen_fall = 1'b0;
    logic pl = 1'b0;
    width = 8'(w);
    gap = 8'(g);
    for (int i = 0; i < n + 300; i++) begin
      @(negedge clk);
      if (missed0) misses++;
      if (level0 && !pl) begin
        rises++;
        if (seen_fall && low_run < min_low) min_low = low_run;
      end
      if (!level0 && pl) seen_fall = 1'b1;
      low_run = level0 ? 0 : low_run + 1;
      pl = level0;
      if (i < n) begin
        tick = ($urandom_range(0, 3) == 0);
        if (tick) ticks++;
      end else begin
        tick = 1'b0;
      end
    end
    $display("random w=%0d g=%0d ticks=%0d rises=%0d missed=%0d min_low=%0d",
             w, g, ticks, rises, misses, min_low);
    check("rand_conservation", rises + misses, ticks);
    check("rand_min_low", int'(min_low >= ((g == 0) ? 1 : g)), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_level0", int'(level0), 0);
    check("reset_busy0", int'(busy0), 0);
    check("reset_done0", int'(done0), 0);
    check("reset_missed0", int'(missed0), 0);
    check("reset_level1", int'(level1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // width 3, gap 2, tick at 10
    push(RISE, 11); push(BUP, 11); push(FALL, 14); push(DONE, 14); push(BDN, 16);
    run_scn("basic", 0, 3, 2, 32'h0000_0400, 20, -1, -1);

    // width 0, gap 0, ticks at 5 and 6
    push(RISE, 6); push(BUP, 6); push(FALL, 7); push(DONE, 7);
    push(RISE, 8); push(FALL, 9); push(DONE, 9); push(BDN, 10);
    run_scn("zero_ops", 0, 0, 0, 32'h0000_0060, 12, -1, -1);

    // no retrigger: width 4, gap 2, ticks at 0, 2, 3
    push(RISE, 1); push(BUP, 1); push(MISS, 4); push(FALL, 5); push(DONE, 5);
    push(RISE, 7); push(FALL, 11); push(DONE, 11); push(BDN, 13);
    run_scn("pending", 0, 4, 2, 32'h0000_000D, 16, -1, -1);

    // retrigger: width 4, gap 2, ticks at 0 and 3
    push(RISE, 1); push(BUP, 1); push(FALL, 8); push(DONE, 8); push(BDN, 10);
    run_scn("retrig", 1, 4, 2, 32'h0000_0009, 14, -1, -1);

    // retrigger on the counter-zero cycle: width 2, gap 1, ticks at 0 and 2
    push(RISE, 1); push(BUP, 1); push(FALL, 5); push(DONE, 5); push(BDN, 6);
    run_scn("retrig_last", 1, 2, 1, 32'h0000_0005, 10, -1, -1);

    // gap end with pending and a fresh tick: width 1, gap 3, ticks at 0, 2, 4
    push(RISE, 1); push(BUP, 1); push(FALL, 2); push(DONE, 2);
    push(RISE, 5); push(MISS, 5); push(FALL, 6); push(DONE, 6); push(BDN, 9);
    run_scn("gap_edge", 0, 1, 3, 32'h0000_0015, 12, -1, -1);

    // async reset during a 10-cycle pulse, pending tick at 2 must be lost
    push(RISE, 1); push(BUP, 1); push(FALL, 3); push(BDN, 3);
    push(RISE, 9); push(BUP, 9); push(FALL, 19); push(DONE, 19); push(BDN, 20);
    run_scn("reset_abort", 0, 10, 1, 32'h0000_0105, 24, 3, 5);

    run_rand(3, 2, 300);
    run_rand(0, 0, 300);
    run_rand(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
